// File: rtl/exhaustive_vector_checker_pkg.sv
// Shared types and defaults for the exhaustive vector checker.
package exhaustive_vector_checker_pkg;

  localparam int DEF_N_IN   = 4;
  localparam int DEF_SETTLE = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_APPLY,
    ST_SETTLE,
    ST_COMPARE,
    ST_DONE
  } state_t;

  // Settle counter width: clog2(settle+1), never below one bit.
  function automatic int timer_w(input int settle);
    return (settle < 1) ? 1 : $clog2(settle + 1);
  endfunction

endpackage

// File: rtl/exhaustive_vector_checker_settle_timer.sv
// Load-and-count-down timer with a zero flag, used to hold each vector
// for the settle interval before its outputs are compared.
module settle_timer #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         dec,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] cnt;

  // Load has priority; counting stops at zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      cnt <= '0;
    else if (load)
      cnt <= load_val;
    else if (dec && (cnt != '0))
      cnt <= cnt - 1'b1;
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/exhaustive_vector_checker.sv
// Drives every input combination to a circuit under test and its reference,
// waits for outputs to settle, compares them and reports a pass/fail summary.
module exhaustive_vector_checker
  import exhaustive_vector_checker_pkg::*;
#(
  parameter int N_IN   = DEF_N_IN,
  parameter int SETTLE = DEF_SETTLE
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            f_dut,
  input  logic            f_ref,
  output logic [N_IN-1:0] vec_out,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [N_IN:0]   mismatch_cnt,
  output logic [N_IN-1:0] first_fail_vec,
  output logic            first_fail_valid
);

  localparam int            TW       = timer_w(SETTLE);
  localparam logic [TW-1:0] LOAD_VAL = TW'((SETTLE > 0) ? SETTLE - 1 : 0);

  state_t        state, state_nxt;
  logic          tmr_zero;
  logic          last_vec;
  logic          mismatch;
  logic [N_IN:0] cnt_nxt;

  assign last_vec = (vec_out == '1);
  assign mismatch = f_dut ^ f_ref;
  // Saturating count; the all-ones value is held once reached.
  assign cnt_nxt  = (mismatch && !(&mismatch_cnt)) ? mismatch_cnt + 1'b1
                                                   : mismatch_cnt;

  settle_timer #(
    .W(TW)
  ) u_timer (
    .clk     (clk),
    .rst     (rst),
    .load    (state == ST_APPLY),
    .dec     (state == ST_SETTLE),
    .load_val(LOAD_VAL),
    .zero    (tmr_zero)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Next-state: one APPLY, SETTLE cycles of settle, one COMPARE per vector.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:    if (start) state_nxt = ST_APPLY;
      ST_APPLY:   state_nxt = (SETTLE == 0) ? ST_COMPARE : ST_SETTLE;
      ST_SETTLE:  if (tmr_zero) state_nxt = ST_COMPARE;
      ST_COMPARE: state_nxt = last_vec ? ST_DONE : ST_APPLY;
      ST_DONE:    if (start) state_nxt = ST_APPLY;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  // Registered outputs: clear on start acceptance, accumulate on each compare.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vec_out          <= '0;
      busy             <= 1'b0;
      done             <= 1'b0;
      pass             <= 1'b0;
      mismatch_cnt     <= '0;
      first_fail_vec   <= '0;
      first_fail_valid <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            vec_out          <= '0;
            busy             <= 1'b1;
            done             <= 1'b0;
            pass             <= 1'b0;
            mismatch_cnt     <= '0;
            first_fail_vec   <= '0;
            first_fail_valid <= 1'b0;
          end
        end
        ST_COMPARE: begin
          mismatch_cnt <= cnt_nxt;
          if (mismatch && !first_fail_valid) begin
            first_fail_vec   <= vec_out;
            first_fail_valid <= 1'b1;
          end
          // The all-ones vector ends the run; the vector never wraps.
          if (last_vec) begin
            busy <= 1'b0;
            done <= 1'b1;
            pass <= (cnt_nxt == '0);
          end else begin
            vec_out <= vec_out + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_exhaustive_vector_checker.sv
// Scoreboard bench: expected run results are queued when a run is started and
// checked when done rises; a monitor also checks per-vector stepping and hold.
module tb_exhaustive_vector_checker;

  localparam int N    = 4;
  localparam int ST_A = 2;
  localparam int ST_B = 0;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start_a = 1'b0, start_b = 1'b0;
  logic         fd_a, fr_a, fd_b, fr_b;
  logic [N-1:0] vec_a, vec_b, ffvec_a, ffvec_b;
  logic         busy_a, busy_b, done_a, done_b, pass_a, pass_b, ffv_a, ffv_b;
  logic [N:0]   cnt_a, cnt_b;

  int mode = 0;
  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;

  typedef struct {
    int cnt;
    int pass;
    int ffv;
    int ffvec;
    int lat;
  } exp_t;

  exp_t exp_q[$];
  exp_t e_mon;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // x = v[3], y = v[2], z = v[1], q = v[0]
  function automatic logic f_ref_m(input int m, input logic [N-1:0] v);
    if (m == 1) return v[3] & v[2];
    return (v[3] & v[2]) | v[1];
  endfunction

  function automatic logic f_dut_m(input int m, input logic [N-1:0] v);
    if (m == 1) return 1'b0;
    return (v[3] & v[2]) | v[1];
  endfunction

  function automatic exp_t model(input int m, input int settle);
    exp_t e;
    e.cnt = 0; e.ffv = 0; e.ffvec = 0;
    for (int v = 0; v < (1 << N); v++) begin
      if (f_dut_m(m, v[N-1:0]) != f_ref_m(m, v[N-1:0])) begin
        if (e.ffv == 0) begin e.ffv = 1; e.ffvec = v; end
        e.cnt++;
      end
    end
    e.pass = (e.cnt == 0) ? 1 : 0;
    e.lat  = (1 << N) * (settle + 2);
    return e;
  endfunction

  assign fd_a = f_dut_m(mode, vec_a);
  assign fr_a = f_ref_m(mode, vec_a);
  assign fd_b = f_dut_m(0, vec_b);
  assign fr_b = f_ref_m(0, vec_b);

  exhaustive_vector_checker #(.N_IN(N), .SETTLE(ST_A)) u_dut_a (
    .clk(clk), .rst(rst), .start(start_a), .f_dut(fd_a), .f_ref(fr_a),
    .vec_out(vec_a), .busy(busy_a), .done(done_a), .pass(pass_a),
    .mismatch_cnt(cnt_a), .first_fail_vec(ffvec_a), .first_fail_valid(ffv_a)
  );

  exhaustive_vector_checker #(.N_IN(N), .SETTLE(ST_B)) u_dut_b (
    .clk(clk), .rst(rst), .start(start_b), .f_dut(fd_b), .f_ref(fr_b),
    .vec_out(vec_b), .busy(busy_b), .done(done_b), .pass(pass_b),
    .mismatch_cnt(cnt_b), .first_fail_vec(ffvec_b), .first_fail_valid(ffv_b)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0d want %0d", tag, got, want);
    end
  endtask

  task automatic chk_zero_a(input string tag);
    chk({tag, "_vec"}, vec_a, 0);
    chk({tag, "_busy"}, busy_a, 0);
    chk({tag, "_done"}, done_a, 0);
    chk({tag, "_pass"}, pass_a, 0);
    chk({tag, "_cnt"}, cnt_a, 0);
    chk({tag, "_ffvec"}, ffvec_a, 0);
    chk({tag, "_ffv"}, ffv_a, 0);
  endtask

  // Monitor for DUT A: vector stepping, hold length, end-of-run scoreboard.
  logic         busy_q = 1'b0, done_q = 1'b0;
  logic [N-1:0] pvec = '0;
  int           hold = 0;
  int           t_acc = 0;

  always @(negedge clk) begin
    if (rst) begin
      busy_q <= 1'b0;
      done_q <= 1'b0;
      hold   <= 0;
    end else begin
      if (busy_a && !busy_q) begin
        chk("vec_first", vec_a, 0);
        hold  <= 1;
        t_acc <= cyc;
      end else if (busy_a) begin
        if (vec_a == pvec) hold <= hold + 1;
        else begin
          chk("hold", hold, ST_A + 2);
          chk("vec_step", vec_a, pvec + 1);
          hold <= 1;
        end
      end
      if (done_a && !done_q) begin
        chk("hold_last", hold, ST_A + 2);
        chk("vec_last", vec_a, (1 << N) - 1);
        if (exp_q.size() == 0) chk("sb_underflow", 0, 1);
        else begin
          e_mon = exp_q.pop_front();
          chk("latency", cyc - t_acc, e_mon.lat);
          chk("mismatch_cnt", cnt_a, e_mon.cnt);
          chk("pass", pass_a, e_mon.pass);
          chk("ffv", ffv_a, e_mon.ffv);
          chk("ffvec", ffvec_a, e_mon.ffvec);
        end
      end
      busy_q <= busy_a;
      done_q <= done_a;
      pvec   <= vec_a;
    end
  end

  // Waits for a rising done on DUT A, bounded.
  task automatic wait_done_a(input string tag);
    bit low = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (!done_a) low = 1'b1;
      else if (low) return;
    end
    chk({tag, "_done_timeout"}, 0, 1);
  endtask

  // Queues the expected result and pulses start; checks acceptance clears.
  task automatic run_a(input string tag);
    exp_q.push_back(model(mode, ST_A));
    @(negedge clk); start_a = 1'b1;
    @(negedge clk); start_a = 1'b0;
    chk({tag, "_acc_busy"}, busy_a, 1);
    chk({tag, "_acc_done"}, done_a, 0);
    chk({tag, "_acc_ffv"}, ffv_a, 0);
    chk({tag, "_acc_cnt"}, cnt_a, 0);
    wait_done_a(tag);
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: got timeout want completion");
    $fatal(1, "bench timeout");
  end

  initial begin
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk_zero_a("reset");
    chk("reset_b_done", done_b, 0);
    #1 rst = 1'b0;

    // Identical functions: clean pass.
    mode = 0;
    run_a("match");

    // f_ref = x&y, f_dut = 0: four failures from 4'b1100.
    mode = 1;
    run_a("fail");

    // Rerun from DONE with a matching DUT.
    mode = 0;
    run_a("rerun");

    // Async reset mid-run at vector 5, then a clean run.
    @(negedge clk); start_a = 1'b1;
    @(negedge clk); start_a = 1'b0;
    for (int i = 0; i < 200 && vec_a != 5; i++) @(negedge clk);
    chk("abort_reach_vec5", vec_a, 5);
    @(posedge clk);
    #2 rst = 1'b1;
    #1 chk_zero_a("rst_async");
    @(negedge clk);
    #1 rst = 1'b0;
    run_a("after_rst");

    // start held high through a run and into DONE.
    exp_q.push_back(model(mode, ST_A));
    @(negedge clk); start_a = 1'b1;
    wait_done_a("held");
    exp_q.push_back(model(mode, ST_A));
    @(negedge clk);
    chk("held_restart_busy", busy_a, 1);
    chk("held_restart_vec", vec_a, 0);
    chk("held_restart_cnt", cnt_a, 0);
    chk("held_restart_done", done_a, 0);
    start_a = 1'b0;
    wait_done_a("held2");

    // SETTLE = 0: each vector held two cycles, done 32 cycles after start.
    @(negedge clk); start_b = 1'b1;
    @(negedge clk); start_b = 1'b0;
    for (int v = 0; v < (1 << N); v++) begin
      for (int h = 0; h < 2; h++) begin
        if (v != 0 || h != 0) @(negedge clk);
        chk("b_vec", vec_b, v);
      end
      chk("b_busy", busy_b, 1);
    end
    @(negedge clk);
    chk("b_done", done_b, 1);
    chk("b_pass", pass_b, 1);
    chk("b_cnt", cnt_b, 0);
    chk("b_ffv", ffv_b, 0);

    chk("sb_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
